segment_id_ex_hz: RTL

Parametrised ID/EX pipeline segment register for the MyISA core, generalising the fixed 32-bit ID/EX segment.
- Carries decode-stage control and operands into execute.
- Adds per-stage valid tracking, stall (hold), flush (bubble insertion) and source-register tags for the forwarding unit.
- Adds saturating bubble/stall performance counters and a stall watchdog.
- Sits between the decode stage and the ALU/execute stage; driven by the hazard unit.

---
 rtl/segment_id_ex_hz.sv | 129 ++++++++++++
 1 files changed

// File: rtl/segment_id_ex_hz.sv
// ID/EX segment register: carries decode control and operands into execute on the falling edge,
// with valid tracking, stall/flush handling, bubble/stall counters and a stall watchdog.
module segment_id_ex_hz #(
   parameter int DATA_W      = 32,
   parameter int REGADDR_W   = 4,
   parameter int ALUCTL_W    = 3,
   parameter int CNT_W       = 16,
   parameter int STALL_LIMIT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stallE,
   input  logic                 flushE,
   input  logic                 validD,
   input  logic                 RegWriteD,
   input  logic                 MemtoRegD,
   input  logic                 MemWriteD,
   input  logic                 ALUSrcD,
   input  logic                 FlagsWriteD,
   input  logic [ALUCTL_W-1:0]  ALUControlD,
   input  logic [REGADDR_W-1:0] WA3D,
   input  logic [REGADDR_W-1:0] RA1D,
   input  logic [REGADDR_W-1:0] RA2D,
   input  logic [DATA_W-1:0]    rd1D,
   input  logic [DATA_W-1:0]    rd2D,
   input  logic [DATA_W-1:0]    ExtImmD,
   output logic                 validE,
   output logic                 RegWriteE,
   output logic                 MemtoRegE,
   output logic                 MemWriteE,
   output logic                 ALUSrcE,
   output logic                 FlagsWriteE,
   output logic [ALUCTL_W-1:0]  ALUControlE,
   output logic [REGADDR_W-1:0] WA3E,
   output logic [REGADDR_W-1:0] RA1E,
   output logic [REGADDR_W-1:0] RA2E,
   output logic [DATA_W-1:0]    rd1E,
   output logic [DATA_W-1:0]    rd2E,
   output logic [DATA_W-1:0]    ExtImmE,
   output logic [CNT_W-1:0]     bubble_count,
   output logic [CNT_W-1:0]     stall_count,
   output logic                 stall_timeout
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

   logic             stall_edge;
   logic             bubble_edge;
   logic [CNT_W-1:0] run_count;
   logic [CNT_W-1:0] run_next;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   assign stall_edge  = stallE & ~flushE;
   assign bubble_edge = flushE | (~stallE & ~validD);
   assign run_next    = sat_inc(run_count);

   // Execute-stage capture: flush beats stall beats load
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         validE      <= 1'b0;
         RegWriteE   <= 1'b0;
         MemtoRegE   <= 1'b0;
         MemWriteE   <= 1'b0;
         ALUSrcE     <= 1'b0;
         FlagsWriteE <= 1'b0;
         ALUControlE <= '0;
         WA3E        <= '0;
         RA1E        <= '0;
         RA2E        <= '0;
         rd1E        <= '0;
         rd2E        <= '0;
         ExtImmE     <= '0;
      end else if (flushE) begin
         validE      <= 1'b0;
         RegWriteE   <= 1'b0;
         MemtoRegE   <= 1'b0;
         MemWriteE   <= 1'b0;
         ALUSrcE     <= 1'b0;
         FlagsWriteE <= 1'b0;
         ALUControlE <= '0;
         WA3E        <= '0;
         RA1E        <= '0;
         RA2E        <= '0;
         rd1E        <= '0;
         rd2E        <= '0;
         ExtImmE     <= '0;
      end else if (!stallE) begin
         // Invalid slots keep their data but must not cause architectural side effects
         validE      <= validD;
         RegWriteE   <= RegWriteD & validD;
         MemtoRegE   <= MemtoRegD & validD;
         MemWriteE   <= MemWriteD & validD;
         ALUSrcE     <= ALUSrcD;
         FlagsWriteE <= FlagsWriteD & validD;
         ALUControlE <= ALUControlD;
         WA3E        <= WA3D;
         RA1E        <= RA1D;
         RA2E        <= RA2D;
         rd1E        <= rd1D;
         rd2E        <= rd2D;
         ExtImmE     <= ExtImmD;
      end
   end

   // Performance counters and stall watchdog
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         bubble_count  <= '0;
         stall_count   <= '0;
         run_count     <= '0;
         stall_timeout <= 1'b0;
      end else begin
         if (bubble_edge)
            bubble_count <= sat_inc(bubble_count);
         if (stall_edge) begin
            stall_count <= sat_inc(stall_count);
            run_count   <= run_next;
            if (run_next >= LIMIT)
               stall_timeout <= 1'b1;
         end else begin
            run_count <= '0;
         end
      end
   end

endmodule
